// File: rtl/uart_rx_packer_pkg.sv
// Shared UART definitions used by the receive path (and the matching transmitter).
//   rx_state_t        : receiver FSM state encoding
//   UART_CLK_PER_BIT  : default clocks per bit (100 MHz / 115200 baud)
//   BYTES_PER_WORD    : bytes gathered into one output word
package uart_rx_packer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  localparam int UART_CLK_PER_BIT = 868;
  localparam int BYTES_PER_WORD   = 4;

endpackage

// File: rtl/uart_rx_core.sv
// UART 8N1 receiver core: rxd synchroniser, baud counter and framing FSM.
// Ports:
//   clk        : system clock
//   rstn       : synchronous active-low reset
//   rxd        : asynchronous serial input, idle high
//   byte_o     : last received byte, valid while byte_valid_o is high
//   byte_valid_o : high in the cycle the stop bit samples 1 (byte accepted)
//   frame_err_o  : one-cycle pulse, the cycle after a stop bit samples 0
//   busy_o     : high whenever the FSM is not in IDLE
module uart_rx_core
  import uart_rx_packer_pkg::*;
#(
  parameter int CLK_PER_BIT = UART_CLK_PER_BIT,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rxd,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int CNT_W = $clog2(CLK_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_PER_BIT / 2 - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  rx_state_t              state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [2:0]             bit_q;
  logic [7:0]             shift_q;
  logic                   frame_err_q;
  logic                   rx_s;

  assign rx_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync_q      <= '1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], rxd};
      frame_err_q <= 1'b0;
      cnt_q       <= cnt_q + CNT_W'(1);
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (!rx_s) state_q <= START;
        end
        START: begin
          // Mid start bit: a line that is high again was only a glitch.
          if (cnt_q == CNT_HALF) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= rx_s ? IDLE : DATA;
          end
        end
        DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            shift_q <= {rx_s, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= STOP;
          end
        end
        STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q       <= '0;
            frame_err_q <= !rx_s;
            state_q     <= rx_s ? IDLE : BREAK;
          end
        end
        BREAK: begin
          // Hold here while the line stays low so a break cannot retrigger.
          cnt_q <= '0;
          if (rx_s) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Accept is decoded from the stop-sample cycle so the packer can register
  // the finished word on the very same edge.
  assign byte_valid_o = (state_q == STOP) && (cnt_q == CNT_LAST) && rx_s;
  assign byte_o       = shift_q;
  assign frame_err_o  = frame_err_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: rtl/uart_rx_packer.sv
// UART 8N1 receiver plus byte-to-word packer feeding a word buffer write port.
// Every 4 accepted bytes form one little-endian 32-bit word.
// Ports:
//   clk       : system clock
//   rstn      : synchronous active-low reset
//   rxd       : asynchronous serial input, idle high
//   wd        : last completed word (first byte received in [7:0]); held
//   we        : one-cycle write strobe, wd valid in the same cycle
//   frame_err : one-cycle pulse when a stop bit samples 0
//   busy      : receiver FSM not in IDLE
module uart_rx_packer
  import uart_rx_packer_pkg::*;
#(
  parameter int CLK_PER_BIT = UART_CLK_PER_BIT,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rxd,
  output logic [31:0] wd,
  output logic        we,
  output logic        frame_err,
  output logic        busy
);

  localparam int LANE_W = $clog2(BYTES_PER_WORD);
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(BYTES_PER_WORD - 1);

  logic [7:0]        rx_byte;
  logic              byte_valid;

  logic [LANE_W-1:0] lane_q, lane_d;
  logic [31:0]       staging_q, staging_d;
  logic [31:0]       wd_q, wd_d;
  logic              we_q, we_d;

  uart_rx_core #(
    .CLK_PER_BIT (CLK_PER_BIT),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_core (
    .clk          (clk),
    .rstn         (rstn),
    .rxd          (rxd),
    .byte_o       (rx_byte),
    .byte_valid_o (byte_valid),
    .frame_err_o  (frame_err),
    .busy_o       (busy)
  );

  always_comb begin
    lane_d    = lane_q;
    staging_d = staging_q;
    wd_d      = wd_q;
    we_d      = 1'b0;
    if (byte_valid) begin
      staging_d[8*lane_q +: 8] = rx_byte;
      lane_d                   = lane_q + LANE_W'(1);
      // The last byte bypasses staging so the word is out one cycle later.
      if (lane_q == LANE_LAST) begin
        wd_d = {rx_byte, staging_q[23:0]};
        we_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      lane_q    <= '0;
      staging_q <= '0;
      wd_q      <= '0;
      we_q      <= 1'b0;
    end else begin
      lane_q    <= lane_d;
      staging_q <= staging_d;
      wd_q      <= wd_d;
      we_q      <= we_d;
    end
  end

  assign wd = wd_q;
  assign we = we_q;

endmodule

// File: tb/tb_uart_rx_packer.sv
module tb_uart_rx_packer;

  localparam int CPB  = 8;
  localparam int SYNC = 2;
  // Cycles from the negedge that drives a start bit to the negedge where the
  // strobe for that frame's stop sample is visible.
  localparam int LAT  = SYNC + 1 + CPB / 2 + 9 * CPB;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rxd = 1'b1;
  logic [31:0] wd;
  logic        we;
  logic        frame_err;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    logic [7:0]  data;
    logic        stop;
    int          gap;
    int          pre;     // 0 none, 1 start glitch first, 2 line break first
    logic        exp_we;
    logic [31:0] exp_wd;
    logic        exp_ferr;
  } vec_t;

  typedef struct {
    logic [31:0] word;
    int          cyc;
  } exp_t;

  vec_t tbl[17];
  exp_t wq[$];
  int   fq[$];
  logic we_prev = 1'b0;

  uart_rx_packer #(
    .CLK_PER_BIT (CPB),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .rxd       (rxd),
    .wd        (wd),
    .we        (we),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard side: every strobe must match the head of its queue.
  always @(negedge clk) begin
    exp_t e;
    if (we) begin
      check("we_consecutive", {31'b0, we_prev}, 32'd0);
      if (wq.size() == 0) check("we_unexpected", {31'b0, we}, 32'd0);
      else begin
        e = wq.pop_front();
        check("wd", wd, e.word);
        check("we_cycle", cyc, e.cyc);
      end
    end
    if (frame_err) begin
      if (fq.size() == 0) check("ferr_unexpected", {31'b0, frame_err}, 32'd0);
      else check("ferr_cycle", cyc, fq.pop_front());
    end
    if (we || frame_err) check("we_ferr_overlap", {31'b0, we & frame_err}, 32'd0);
    we_prev = we;
  end

  // Caller is at a negedge; returns at a negedge.
  task automatic send_byte(input logic [7:0] data, input logic stop, input int gap);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int b = 0; b < 8; b++) begin
      rxd = data[b];
      repeat (CPB) @(negedge clk);
    end
    rxd = stop;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic glitch();
    rxd = 1'b0;
    repeat (2) @(negedge clk);
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    check("glitch_busy_in_start", {31'b0, busy}, 32'd1);
    repeat (10) @(negedge clk);
    check("glitch_back_idle", {31'b0, busy}, 32'd0);
  endtask

  task automatic line_break();
    fq.push_back(cyc + LAT);
    rxd = 1'b0;
    repeat (90) @(negedge clk);
    check("break_busy_held", {31'b0, busy}, 32'd1);
    repeat (10) @(negedge clk);
    rxd = 1'b1;
    repeat (8) @(negedge clk);
    check("break_released", {31'b0, busy}, 32'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((wq.size() != 0 || fq.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("word_q_drained", wq.size(), 32'd0);
    check("ferr_q_drained", fq.size(), 32'd0);
  endtask

  initial begin
    int s;
    int bad;

    tbl[0]  = '{8'h78, 1'b1, 0, 0, 1'b0, 32'h0,        1'b0};
    tbl[1]  = '{8'h56, 1'b1, 0, 0, 1'b0, 32'h0,        1'b0};
    tbl[2]  = '{8'h34, 1'b1, 0, 0, 1'b0, 32'h0,        1'b0};
    tbl[3]  = '{8'h12, 1'b1, 0, 0, 1'b1, 32'h12345678, 1'b0};
    tbl[4]  = '{8'hAA, 1'b0, 8, 0, 1'b0, 32'h0,        1'b1};
    tbl[5]  = '{8'h11, 1'b1, 0, 0, 1'b0, 32'h0,        1'b0};
    tbl[6]  = '{8'h22, 1'b1, 0, 0, 1'b0, 32'h0,        1'b0};
    tbl[7]  = '{8'h33, 1'b1, 0, 0, 1'b0, 32'h0,        1'b0};
    tbl[8]  = '{8'h44, 1'b1, 0, 0, 1'b1, 32'h44332211, 1'b0};
    tbl[9]  = '{8'hC3, 1'b1, 0, 1, 1'b0, 32'h0,        1'b0};
    tbl[10] = '{8'h5A, 1'b1, 0, 0, 1'b0, 32'h0,        1'b0};
    tbl[11] = '{8'h0F, 1'b1, 0, 0, 1'b0, 32'h0,        1'b0};
    tbl[12] = '{8'hF0, 1'b1, 0, 0, 1'b1, 32'hF00F5AC3, 1'b0};
    tbl[13] = '{8'h9E, 1'b1, 0, 2, 1'b0, 32'h0,        1'b0};
    tbl[14] = '{8'h01, 1'b1, 0, 0, 1'b0, 32'h0,        1'b0};
    tbl[15] = '{8'h80, 1'b1, 0, 0, 1'b0, 32'h0,        1'b0};
    tbl[16] = '{8'h7F, 1'b1, 0, 0, 1'b1, 32'h7F80019E, 1'b0};

    // Reset state
    rstn = 1'b0;
    rxd  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_wd", wd, 32'd0);
    check("rst_we", {31'b0, we}, 32'd0);
    check("rst_ferr", {31'b0, frame_err}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    rstn = 1'b1;

    // Idle line stays quiet
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (we || frame_err || busy || wd != 32'd0) bad++;
    end
    check("idle_quiet_cycles", bad, 32'd0);

    // Frame table
    for (int i = 0; i < 17; i++) begin
      if (tbl[i].pre == 1) glitch();
      else if (tbl[i].pre == 2) line_break();
      s = cyc;
      if (tbl[i].exp_we) wq.push_back('{word: tbl[i].exp_wd, cyc: s + LAT});
      if (tbl[i].exp_ferr) fq.push_back(s + LAT);
      send_byte(tbl[i].data, tbl[i].stop, tbl[i].gap);
    end
    drain();
    check("wd_held", wd, 32'h7F80019E);

    // Reset mid-word discards the partial word
    send_byte(8'h01, 1'b1, 0);
    send_byte(8'h02, 1'b1, 0);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    check("midword_rst_wd", wd, 32'd0);
    send_byte(8'hDE, 1'b1, 0);
    send_byte(8'hAD, 1'b1, 0);
    send_byte(8'hBE, 1'b1, 0);
    wq.push_back('{word: 32'hEFBEADDE, cyc: cyc + LAT});
    send_byte(8'hEF, 1'b1, 20);
    drain();
    check("wd_after_rst_word", wd, 32'hEFBEADDE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
